binary_morph_stage: RTL and testbench
=====================================

# binary_morph_stage

Pipelined 3x3 binary morphology stage that consumes the window stream produced by the binary line buffer and emits one filtered binary pixel per valid window. It applies a per-frame operation (pass, erode, dilate, majority), tracks window position within the frame, flags the last output pixel of each frame, and optionally counts set output pixels per frame for the edge-density logic downstream.

## Interface
- WIN_PER_FRAME, 304964: valid windows per frame, (640-2)*(480-2); legal range 1 to 2^20-1.
- CNT_W, 20: width of the window counter and edge counter.
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- win_valid  input  1  window qualifier; one window accepted per high cycle.
- win  input  9  3x3 window, [8:6] top row, [5:3] middle, [2:0] bottom; within a row the MSB is the leftmost column; win[4] is the centre.
- op_sel  input  2  requested operation: 00 pass, 01 erode, 10 dilate, 11 majority.
- frame_sync  input  1  single-cycle pulse; aborts the current frame and re-arms for a new one.
- out_valid  output  1  output pixel qualifier.
- out_pixel  output  1  filtered pixel.
- frame_done  output  1  high with out_valid on the last pixel of a frame.
- edge_count  output  CNT_W  count of out_pixel==1 in the last completed frame.

## Operation
- FSM states: IDLE (no window yet in frame), ACTIVE (mid-frame).
- IDLE + win_valid: latch op_sel into op_frame, set win_cnt=1, go ACTIVE; if WIN_PER_FRAME==1, mark the window last and stay IDLE.
- ACTIVE + win_valid: win_cnt+1. If win_cnt==WIN_PER_FRAME-1, mark the window last, clear win_cnt, go IDLE.
- op_sel is sampled only on the first window of a frame; changes mid-frame are ignored until the next frame.
- frame_sync: clears win_cnt, the stats accumulator and any in-flight last flag; forces IDLE. If win_valid is high in the same cycle, that window becomes window 1 of the new frame with op_sel latched from that cycle. In-flight pipeline pixels still emerge, with frame_done suppressed.
- Stage 1 registers popcount(win) (4 bits, 0..9), win[4], the op, and the last flag, with s1_valid.
- Stage 2 computes out_pixel:
  - pass = centre.
  - erode = (pop==9).
  - dilate = (pop!=0).
  - majority = (pop>=5).
- Stage 2 registers out_valid, out_pixel, and frame_done = s1_valid & s1_last.
- Idle cycles (win_valid low) insert bubbles. There is no backpressure, and every accepted window produces exactly one output.
- Stats accumulator: adds out_pixel on every out_valid, saturating at 2^CNT_W-1. When frame_done is high, edge_count <= accumulator value including this pixel, and the accumulator is cleared.

## Timing
- Latency: 2 cycles from a win_valid edge to out_valid. Throughput: 1 window/cycle.
- Reset values:
  - out_valid=0, out_pixel=0, frame_done=0, edge_count=0.
  - FSM=IDLE, win_cnt=0, op_frame=00, pipeline valids=0.
- Reset mid-frame discards all in-flight windows. No output is produced for them.
- frame_done is a 1-cycle pulse and is never high without out_valid.
- edge_count updates on the same edge where frame_done rises, and holds until the next frame_done.

## Configuration
- MORPH_STATS_EN defined: accumulator and edge_count are implemented as described.
- MORPH_STATS_EN undefined: no accumulator is implemented, and edge_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, state IDLE.
- WIN_PER_FRAME=4, op_sel=01, windows 9'h1FF, 9'h1EF, 9'h1FF, 9'h010 back-to-back -> out_pixel 1,0,1,0 on cycles 2..5; frame_done only on cycle 5; edge_count=2 from cycle 5.
- Same frame with op_sel=11 and windows 9'h01F (pop 5), 9'h00F (pop 4), and two of 9'h000; op_sel switched to 10 after window 1 -> outputs 1,0,0,0 (majority held for the whole frame).
- win_valid gapped every other cycle, op 10, window 9'h001 -> each out_valid exactly 2 cycles after its input, out_pixel=1, with bubbles preserved.
- frame_sync together with window 3 of 4 -> no frame_done for the aborted frame; frame_done occurs 3 windows later; edge_count reflects only the new frame.
- Build without MORPH_STATS_EN and repeat scenario 2 -> identical out_pixel/frame_done, edge_count stays 0.

Source files
------------

// File: rtl/binary_morph_stage.sv
// Two-stage 3x3 binary morphology (pass/erode/dilate/majority) with per-frame op latch and frame tracking.
// Optional MORPH_STATS_EN adds a saturating per-frame count of set output pixels on edge_count.
module binary_morph_stage #(
  parameter int WIN_PER_FRAME = 304964,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             win_valid,
  input  logic [8:0]       win,
  input  logic [1:0]       op_sel,
  input  logic             frame_sync,
  output logic             out_valid,
  output logic             out_pixel,
  output logic             frame_done,
  output logic [CNT_W-1:0] edge_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_PER_FRAME - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [1:0]       op_frame_q, op_frame_d;
  logic [1:0]       win_op;
  logic             win_last;
  logic [3:0]       win_pop;

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_pop_q, s1_pop_d;
  logic             s1_centre_q, s1_centre_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic             s1_last_q, s1_last_d;

  logic             out_valid_q, out_valid_d;
  logic             out_pixel_q, out_pixel_d;
  logic             frame_done_q, frame_done_d;
  logic             morph_bit;

  // Frame tracking: a window accepted with frame_sync is window 1 of the new frame.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    op_frame_d = op_frame_q;
    win_op     = op_frame_q;
    win_last   = 1'b0;
    if (frame_sync) begin
      state_d   = IDLE;
      win_cnt_d = '0;
    end
    if (win_valid) begin
      if (frame_sync || state_q == IDLE) begin
        op_frame_d = op_sel;
        win_op     = op_sel;
        if (WIN_PER_FRAME == 1) begin
          win_last  = 1'b1;
          state_d   = IDLE;
          win_cnt_d = '0;
        end else begin
          state_d   = ACTIVE;
          win_cnt_d = CNT_W'(1);
        end
      end else if (win_cnt_q == LAST_CNT) begin
        win_last  = 1'b1;
        state_d   = IDLE;
        win_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    win_pop = 4'd0;
    for (int i = 0; i < 9; i++) begin
      win_pop = win_pop + {3'b000, win[i]};
    end
  end

  always_comb begin
    s1_valid_d  = win_valid;
    s1_pop_d    = win_pop;
    s1_centre_d = win[4];
    s1_op_d     = win_op;
    s1_last_d   = win_valid & win_last;
  end

  always_comb begin
    unique case (s1_op_q)
      2'b00:   morph_bit = s1_centre_q;
      2'b01:   morph_bit = (s1_pop_q == 4'd9);
      2'b10:   morph_bit = (s1_pop_q != 4'd0);
      default: morph_bit = (s1_pop_q >= 4'd5);
    endcase
    out_valid_d  = s1_valid_q;
    out_pixel_d  = s1_valid_q & morph_bit;
    // A sync kills the last flag of the window already in stage 1.
    frame_done_d = s1_valid_q & s1_last_q & ~frame_sync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      op_frame_q   <= 2'b00;
      s1_valid_q   <= 1'b0;
      s1_pop_q     <= 4'd0;
      s1_centre_q  <= 1'b0;
      s1_op_q      <= 2'b00;
      s1_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      op_frame_q   <= op_frame_d;
      s1_valid_q   <= s1_valid_d;
      s1_pop_q     <= s1_pop_d;
      s1_centre_q  <= s1_centre_d;
      s1_op_q      <= s1_op_d;
      s1_last_q    <= s1_last_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign frame_done = frame_done_q;

`ifdef MORPH_STATS_EN
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic [CNT_W:0]   acc_sum;
  logic [CNT_W-1:0] acc_sat;

  // Accumulate from the stage-2 next values so edge_count lands on the frame_done edge.
  always_comb begin
    acc_sum      = {1'b0, acc_q} + {{CNT_W{1'b0}}, out_pixel_d};
    acc_sat      = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
    acc_d        = acc_q;
    edge_count_d = edge_count_q;
    if (frame_sync) begin
      acc_d = '0;
    end else if (out_valid_d) begin
      if (frame_done_d) begin
        edge_count_d = acc_sat;
        acc_d        = '0;
      end else begin
        acc_d = acc_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      edge_count_q <= '0;
    end else begin
      acc_q        <= acc_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign edge_count = edge_count_q;
`else
  assign edge_count = '0;
`endif

endmodule

// File: tb/tb_binary_morph_stage.sv
// Directed bench for binary_morph_stage with WIN_PER_FRAME=4; edge_count expectations follow MORPH_STATS_EN.
module tb_binary_morph_stage;
  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             win_valid = 1'b0;
  logic [8:0]       win = '0;
  logic [1:0]       op_sel = '0;
  logic             frame_sync = 1'b0;
  logic             out_valid;
  logic             out_pixel;
  logic             frame_done;
  logic [CNT_W-1:0] edge_count;

  int checks = 0;
  int errors = 0;

  binary_morph_stage #(.WIN_PER_FRAME(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .win(win), .op_sel(op_sel),
    .frame_sync(frame_sync), .out_valid(out_valid), .out_pixel(out_pixel),
    .frame_done(frame_done), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  function automatic int ec(input int x);
`ifdef MORPH_STATS_EN
    return x;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then check the outputs registered on that edge.
  task automatic step(input string tag, input logic v, input logic [8:0] w, input logic [1:0] op,
                      input logic fs, input logic ev, input logic ep, input logic efd, input int eec);
    win_valid  = v;
    win        = w;
    op_sel     = op;
    frame_sync = fs;
    @(posedge clk);
    #1;
    $display("%s: in v=%0b win=%h op=%0d fs=%0b -> out_valid=%0b pixel=%0b done=%0b edge_count=%0d",
             tag, v, w, op, fs, out_valid, out_pixel, frame_done, edge_count);
    chk({tag, "_valid"}, int'(out_valid), int'(ev));
    if (ev) chk({tag, "_pixel"}, int'(out_pixel), int'(ep));
    chk({tag, "_done"}, int'(frame_done), int'(efd));
    chk({tag, "_count"}, int'(edge_count), eec);
  endtask

  initial begin
    // Reset, then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_count", int'(edge_count), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("idle", 0, 9'h000, 2'b00, 0, 0, 0, 0, 0);

    // Reset mid-frame discards in-flight windows and the window counter
    step("mr1", 1, 9'h1FF, 2'b01, 0, 0, 0, 0, 0);
    step("mr2", 1, 9'h1FF, 2'b01, 0, 1, 1, 0, 0);
    win_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("mr3", 0, 9'h000, 2'b00, 0, 0, 0, 0, 0);

    // Erode frame
    step("er1", 1, 9'h1FF, 2'b01, 0, 0, 0, 0, 0);
    step("er2", 1, 9'h1EF, 2'b01, 0, 1, 1, 0, 0);
    step("er3", 1, 9'h1FF, 2'b01, 0, 1, 0, 0, 0);
    step("er4", 1, 9'h010, 2'b01, 0, 1, 1, 0, 0);
    step("er5", 0, 9'h000, 2'b01, 0, 1, 0, 1, ec(2));
    step("er6", 0, 9'h000, 2'b01, 0, 0, 0, 0, ec(2));

    // Majority frame; op change mid-frame ignored
    step("mj1", 1, 9'h01F, 2'b11, 0, 0, 0, 0, ec(2));
    step("mj2", 1, 9'h00F, 2'b10, 0, 1, 1, 0, ec(2));
    step("mj3", 1, 9'h000, 2'b10, 0, 1, 0, 0, ec(2));
    step("mj4", 1, 9'h000, 2'b10, 0, 1, 0, 0, ec(2));
    step("mj5", 0, 9'h000, 2'b10, 0, 1, 0, 1, ec(1));
    step("mj6", 0, 9'h000, 2'b10, 0, 0, 0, 0, ec(1));

    // Gapped dilate frame: bubbles preserved, 2-cycle latency
    step("gp1", 1, 9'h001, 2'b10, 0, 0, 0, 0, ec(1));
    step("gp2", 0, 9'h000, 2'b10, 0, 1, 1, 0, ec(1));
    step("gp3", 1, 9'h001, 2'b10, 0, 0, 0, 0, ec(1));
    step("gp4", 0, 9'h000, 2'b10, 0, 1, 1, 0, ec(1));
    step("gp5", 1, 9'h001, 2'b10, 0, 0, 0, 0, ec(1));
    step("gp6", 0, 9'h000, 2'b10, 0, 1, 1, 0, ec(1));
    step("gp7", 1, 9'h001, 2'b10, 0, 0, 0, 0, ec(1));
    step("gp8", 0, 9'h000, 2'b10, 0, 1, 1, 1, ec(4));
    step("gp9", 0, 9'h000, 2'b10, 0, 0, 0, 0, ec(4));

    // frame_sync on window 3: new frame (erode) starts with that window
    step("fs1", 1, 9'h010, 2'b10, 0, 0, 0, 0, ec(4));
    step("fs2", 1, 9'h010, 2'b10, 0, 1, 1, 0, ec(4));
    step("fs3", 1, 9'h1FF, 2'b01, 1, 1, 1, 0, ec(4));
    step("fs4", 1, 9'h1EF, 2'b10, 0, 1, 1, 0, ec(4));
    step("fs5", 1, 9'h1FF, 2'b10, 0, 1, 0, 0, ec(4));
    step("fs6", 1, 9'h1FF, 2'b10, 0, 1, 1, 0, ec(4));
    step("fs7", 0, 9'h000, 2'b10, 0, 1, 1, 1, ec(3));
    step("fs8", 0, 9'h000, 2'b10, 0, 0, 0, 0, ec(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
